// File: rtl/sprite_anim_draw_if.sv
// Sprite ROM bus: registered address out, synchronous 9-bit {mask, RRRGGGBB} data back.
interface sprite_anim_draw_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] rom_addr;
  logic [8:0]        rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_anim_draw.sv
// Animated, scalable, mirrorable sprite drawer with a fixed 3-cycle latency
// from VGA coordinate to drawing_request / mVGA_RGB.
module sprite_anim_draw #(
  parameter int OBJ_W      = 32,
  parameter int OBJ_H      = 32,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 8,
  parameter int ADDR_W     = 12,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic [10:0]          oCoord_X,
  input  logic [10:0]          oCoord_Y,
  input  logic [10:0]          ObjectStartX,
  input  logic [10:0]          ObjectStartY,
  input  logic                 enable,
  input  logic                 flip_h,
  input  logic                 flip_v,
  input  logic [1:0]           scale,
  input  logic                 frame_tick,
  input  logic                 anim_en,
  input  logic                 anim_oneshot,
  input  logic                 anim_restart,
  sprite_anim_draw_if.master   rom,
  output logic                 drawing_request,
  output logic [7:0]           mVGA_RGB,
  output logic [FW-1:0]        frame_idx,
  output logic                 anim_done
);

  localparam int CW = $clog2(OBJ_W);
  localparam int RW = $clog2(OBJ_H);
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  logic [1:0]        shift_s;
  logic [11:0]       x_s, y_s, sx_s, sy_s, ex_s, ey_s, dx_s, dy_s;
  logic [CW-1:0]     col_s;
  logic [RW-1:0]     row_s;
  logic              inside_s;
  logic [ADDR_W-1:0] addr_s;

  logic [ADDR_W-1:0] rom_addr_r;
  logic              inside_d1_r, enable_d1_r;
  logic              inside_d2_r, enable_d2_r;
  logic              req_r;
  logic [7:0]        rgb_r;
  logic              opaque_s;

  logic [FW-1:0]     frame_r, frame_nxt_s;
  logic [HW-1:0]     hold_r, hold_nxt_s;
  logic              done_r, done_nxt_s;

  // Sprite bounds, offsets and ROM address; 12-bit math keeps the right/bottom edge from wrapping.
  always_comb begin
    shift_s  = (scale == 2'd3) ? 2'd2 : scale;
    x_s      = {1'b0, oCoord_X};
    y_s      = {1'b0, oCoord_Y};
    sx_s     = {1'b0, ObjectStartX};
    sy_s     = {1'b0, ObjectStartY};
    ex_s     = sx_s + (12'(OBJ_W) << shift_s);
    ey_s     = sy_s + (12'(OBJ_H) << shift_s);
    inside_s = (x_s >= sx_s) && (x_s < ex_s) && (y_s >= sy_s) && (y_s < ey_s);
    dx_s     = x_s - sx_s;
    dy_s     = y_s - sy_s;
    // Power-of-two size: (OBJ_W-1-col) is just the bitwise complement.
    col_s    = CW'(dx_s >> shift_s);
    row_s    = RW'(dy_s >> shift_s);
    col_s    = inside_s ? (flip_h ? ~col_s : col_s) : {CW{1'b0}};
    row_s    = inside_s ? (flip_v ? ~row_s : row_s) : {RW{1'b0}};
    addr_s   = (ADDR_W'(frame_r) << (CW + RW)) | (ADDR_W'(row_s) << CW) | ADDR_W'(col_s);
  end

  // Stages 1 and 2: address out to the ROM, qualifiers follow the ROM read.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rom_addr_r  <= {ADDR_W{1'b0}};
      inside_d1_r <= 1'b0;
      enable_d1_r <= 1'b0;
      inside_d2_r <= 1'b0;
      enable_d2_r <= 1'b0;
    end else begin
      rom_addr_r  <= addr_s;
      inside_d1_r <= inside_s;
      enable_d1_r <= enable;
      inside_d2_r <= inside_d1_r;
      enable_d2_r <= enable_d1_r;
    end
  end

  assign rom.rom_addr = rom_addr_r;
  assign opaque_s     = inside_d2_r & rom.rom_data[8] & enable_d2_r;

  // Stage 3: registered pixel outputs; transparent or disabled pixels output black.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      req_r <= 1'b0;
      rgb_r <= 8'h00;
    end else begin
      req_r <= opaque_s;
      rgb_r <= opaque_s ? rom.rom_data[7:0] : 8'h00;
    end
  end

  // Animation next state: restart wins, otherwise advance only on an enabled tick.
  always_comb begin
    frame_nxt_s = frame_r;
    hold_nxt_s  = hold_r;
    done_nxt_s  = done_r;
    if (anim_restart) begin
      frame_nxt_s = {FW{1'b0}};
      hold_nxt_s  = {HW{1'b0}};
      done_nxt_s  = 1'b0;
    end else if (frame_tick && anim_en && !done_r) begin
      if (hold_r == HW'(FRAME_HOLD - 1)) begin
        hold_nxt_s = {HW{1'b0}};
        if (frame_r < FW'(NUM_FRAMES - 1)) begin
          frame_nxt_s = frame_r + FW'(1);
        end else if (!anim_oneshot) begin
          frame_nxt_s = {FW{1'b0}};
        end else begin
          done_nxt_s = 1'b1;
        end
      end else begin
        hold_nxt_s = hold_r + HW'(1);
      end
    end else begin
      hold_nxt_s = hold_r;
    end
  end

  // Animation state registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      frame_r <= {FW{1'b0}};
      hold_r  <= {HW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      frame_r <= frame_nxt_s;
      hold_r  <= hold_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign drawing_request = req_r;
  assign mVGA_RGB        = rgb_r;
  assign frame_idx       = frame_r;
  assign anim_done       = done_r;

endmodule
